// File: rtl/accelbrot_com_pkg.sv
// Shared types for the word-serial add/subtract stage of the Mandelbrot datapath.
package accelbrot_com_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_RSUB  = 2'd2,
        OP_PASSA = 2'd3
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // A single-word number still needs a 1-bit index so the counter never collapses to zero width.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/accelbrot_com_addsub_word.sv
// Combinational word slice: selects effective operands for the op, adds with carry-in,
// and reports signed overflow from the operand and sum MSBs.
module accelbrot_com_addsub_word
    import accelbrot_com_pkg::*;
#(
    parameter int WWIDTH = 34
) (
    input  logic [WWIDTH-1:0] a_i,
    input  logic [WWIDTH-1:0] b_i,
    input  logic              cin_i,
    input  op_t               op_i,
    output logic [WWIDTH:0]   sum_o,
    output logic              ovf_o
);

    logic [WWIDTH-1:0] x;
    logic [WWIDTH-1:0] y;

    always_comb begin
        x = a_i;
        y = b_i;
        unique case (op_i)
            OP_ADD:   y = b_i;
            OP_SUB:   y = ~b_i;
            OP_RSUB:  begin
                x = b_i;
                y = ~a_i;
            end
            OP_PASSA: y = '0;
            default:  y = b_i;
        endcase
        sum_o = {1'b0, x} + {1'b0, y} + {{WWIDTH{1'b0}}, cin_i};
        ovf_o = (x[WWIDTH-1] == y[WWIDTH-1]) && (sum_o[WWIDTH-1] != x[WWIDTH-1]);
    end

endmodule

// File: rtl/accelbrot_com_addsub.sv
// Word-serial multi-word adder/subtractor: LSW-first operands, carry chained across words,
// registered result with start/last marking, end-of-number carry/overflow and protocol error pulse.
module accelbrot_com_addsub
    import accelbrot_com_pkg::*;
#(
    parameter int WWIDTH    = 34,
    parameter int NUM_WORDS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WWIDTH-1:0] a,
    input  logic [WWIDTH-1:0] b,
    input  logic [1:0]        op,
    input  logic              ab_start,
    input  logic              ab_valid,
    output logic [WWIDTH-1:0] q,
    output logic              q_start,
    output logic              q_last,
    output logic              q_valid,
    output logic              q_carry,
    output logic              q_ovf,
    output logic              err
);

    localparam int CW = cnt_width(NUM_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    op_t               op_q, op_d;
    logic [WWIDTH-1:0] q_q, q_d;
    logic              q_start_q, q_start_d;
    logic              q_last_q, q_last_d;
    logic              q_valid_q, q_valid_d;
    logic              q_carry_q, q_carry_d;
    logic              q_ovf_q, q_ovf_d;
    logic              err_q, err_d;

    op_t               cur_op;
    logic              cin;
    logic [CW-1:0]     idx;
    logic [WWIDTH:0]   sum;
    logic              ovf;
    logic              accept;

    // The start word carries its own op and initial carry; later words reuse the latched ones.
    always_comb begin
        cur_op = ab_start ? op_t'(op) : op_q;
        cin    = ab_start ? ((cur_op == OP_SUB) || (cur_op == OP_RSUB)) : carry_q;
        idx    = ab_start ? '0 : cnt_q;
    end

    accelbrot_com_addsub_word #(
        .WWIDTH(WWIDTH)
    ) u_word (
        .a_i  (a),
        .b_i  (b),
        .cin_i(cin),
        .op_i (cur_op),
        .sum_o(sum),
        .ovf_o(ovf)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        op_d      = op_q;
        q_d       = q_q;
        q_start_d = 1'b0;
        q_last_d  = 1'b0;
        q_valid_d = 1'b0;
        q_carry_d = 1'b0;
        q_ovf_d   = 1'b0;
        err_d     = 1'b0;
        accept    = 1'b0;

        if (ab_valid) begin
            if (ab_start) begin
                accept = 1'b1;
                err_d  = (state_q == ST_BUSY);
                op_d   = cur_op;
            end else if (state_q == ST_BUSY) begin
                accept = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (accept) begin
            q_d       = sum[WWIDTH-1:0];
            carry_d   = sum[WWIDTH];
            q_valid_d = 1'b1;
            q_start_d = ab_start;
            if (idx == LAST_IDX) begin
                q_last_d  = 1'b1;
                q_carry_d = (cur_op == OP_PASSA) ? 1'b0 :
                            (cur_op == OP_ADD)   ? sum[WWIDTH] : ~sum[WWIDTH];
                q_ovf_d   = (cur_op == OP_PASSA) ? 1'b0 : ovf;
                state_d   = ST_IDLE;
                cnt_d     = '0;
            end else begin
                state_d = ST_BUSY;
                cnt_d   = idx + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            op_q      <= OP_ADD;
            q_q       <= '0;
            q_start_q <= 1'b0;
            q_last_q  <= 1'b0;
            q_valid_q <= 1'b0;
            q_carry_q <= 1'b0;
            q_ovf_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            op_q      <= op_d;
            q_q       <= q_d;
            q_start_q <= q_start_d;
            q_last_q  <= q_last_d;
            q_valid_q <= q_valid_d;
            q_carry_q <= q_carry_d;
            q_ovf_q   <= q_ovf_d;
            err_q     <= err_d;
        end
    end

    assign q       = q_q;
    assign q_start = q_start_q;
    assign q_last  = q_last_q;
    assign q_valid = q_valid_q;
    assign q_carry = q_carry_q;
    assign q_ovf   = q_ovf_q;
    assign err     = err_q;

endmodule

// File: doc/accelbrot_com_addsub.md
# accelbrot_com_addsub

Word-serial, multi-word two's-complement adder/subtractor for the Mandelbrot engine's arithmetic datapath. It accepts operands LSW-first, one word per valid cycle, and chains carry/borrow across words. It adds a per-number operation select, a word counter with last-word marking, and end-of-number carry and signed-overflow flags. It sits between the operand sequencers and the multiplier/compare stages, and it generalises the fixed subtract-only word stage.

## Interface
Parameters:
- WWIDTH, 34, word width in bits (≥2)
- NUM_WORDS, 4, words per number (≥1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- a  in  WWIDTH  operand A word
- b  in  WWIDTH  operand B word
- op  in  2  operation, sampled on start word only: ADD a+b, SUB a−b, RSUB b−a, PASSA a
- ab_start  in  1  first (least significant) word of a number; meaningful only with ab_valid
- ab_valid  in  1  a/b/op/ab_start valid this cycle
- q  out  WWIDTH  result word
- q_start  out  1  result word is word 0
- q_last  out  1  result word is word NUM_WORDS−1
- q_valid  out  1  q valid
- q_carry  out  1  unsigned carry-out (ADD) or borrow (SUB/RSUB); valid with q_last; 0 for PASSA
- q_ovf  out  1  signed overflow; valid with q_last; 0 for PASSA
- err  out  1  one-cycle pulse on a protocol error

## Operation
- States: IDLE and BUSY. A word index counter runs 0..NUM_WORDS−1. The latched op and carry are held in registers.
- Effective operands: ADD (a, b, cin0=0); SUB (a, ~b, cin0=1); RSUB (b, ~a, cin0=1); PASSA (a, 0, cin0=0).
- Word sum is x + y + cin, formed as a (WWIDTH+1)-bit result. q takes the low WWIDTH bits. The carry register takes bit WWIDTH.
- On the start word, cin = cin0 and op is latched. On later words, cin is the carry register and the latched op is used. The op input is ignored.
- Borrow: q_carry = ~carry_out for SUB/RSUB, carry_out for ADD.
- Signed overflow on the last word is (x_msb == y_msb) && (sum_msb != x_msb), using the effective operands.
- Cycles with ab_valid=0: no state change and q_valid=0. The carry and counter are held, so gaps are allowed anywhere.
- IDLE + valid + start: output word 0 and go to BUSY. If NUM_WORDS=1, also assert q_last and stay in IDLE.
- IDLE + valid + !start: the word is dropped (q_valid=0) and err pulses.
- BUSY + valid + !start: output the next word. On index NUM_WORDS−1, assert q_last and return to IDLE.
- BUSY + valid + start: the current number is abandoned with no q_last emitted. err pulses. The new word is processed as word 0.

## Timing
- Latency is 1 cycle from the input word to the registered output word. Throughput is one word per clock.
- All outputs are registered. On reset, all outputs are 0, the state is IDLE, the counter is 0, the carry is 0 and the latched op is ADD.
- Reset is asynchronous and takes effect mid-number. The first valid word after reset must carry ab_start, otherwise err pulses.
- q_start and q_last are asserted in the same cycle when NUM_WORDS=1.
- q_carry and q_ovf are 0 whenever q_last=0.
- err asserts in the cycle after the offending input, aligned with the output stage.

## Structure
- Package accelbrot_com_pkg holds:
  - the op_t enum (ADD=0, SUB=1, RSUB=2, PASSA=3);
  - the state enum;
  - the helper function clog2-based counter width.
- Sub-module accelbrot_com_addsub_word is combinational. It takes effective-operand selection, cin and op, and returns the WWIDTH+1 sum and the MSB-based overflow. It is instantiated once.

## Test plan
All scenarios use WWIDTH=8 and NUM_WORDS=2. Words are listed LSW first.
- ADD, a=0x01FF, b=0x0001 → q=0x00,0x02; q_start on the first word, q_last on the second; q_carry=0, q_ovf=0.
- SUB, a=0x0000, b=0x0001 → q=0xFF,0xFF; q_carry(borrow)=1, q_ovf=0.
- ADD, a=0x7FFF, b=0x0001 → q=0x00,0x80; q_ovf=1, q_carry=0. RSUB with a=0x0001, b=0x8000 → q=0xFF,0x7F; q_ovf=1.
- ADD, 0x01FF+0x0001 with three invalid cycles between words, and op toggled on the second word → same result as scenario 1; the carry is held across the gap.
- Start word, then a new start word (SUB, a=5, b=3, 2 words) → first number has no q_last; err pulses once; output q=0x02,0x00 with q_last. A valid non-start word in IDLE → no q_valid; err pulses.
- Assert rstn low between word 0 and word 1 → all outputs are 0 immediately. Next word without start → err pulses; next proper number computes correctly.
